spi_pwm_reg_ctrl: RTL and testbench

//   SPI (mode 0) write-only peripheral that configures the PWM peripheral. Receives 16-bit frames

---
 rtl/spi_pwm_reg_ctrl.sv | 130 +++++++++++++
 tb/tb_spi_pwm_reg_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_reg_ctrl.sv
// SPI mode-0 write-only register port for the PWM peripheral.
// 16-bit frames (R/W, 7-bit address, 8-bit data) arrive on asynchronous pad
// pins, are synchronised into clk, shifted in, and committed on chip-select
// release into one of the five PWM configuration registers.
module spi_pwm_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_copi,
  input  logic              spi_ncs,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  copi_sync;
  logic [SYNC_STAGES-1:0]  ncs_sync;
  logic                    sclk_d;
  logic                    ncs_d;
  logic                    sclk_s;
  logic                    copi_s;
  logic                    ncs_s;
  logic                    sclk_rise;
  logic                    ncs_rise;
  logic                    ncs_fall;
  logic [15:0]             shift;
  logic [4:0]              bit_cnt;
  logic                    ovf;
  logic                    fall_pend;
  logic [ADDR_W-1:0]       addr;
  logic [7:0]              data;
  logic                    frame_ok;
  logic [7:0]              regs [NUM_REGS];

  // Pad synchronisers plus one history flop for edge detection. These are not
  // reset so that a chip select already low when rst releases is not seen as
  // a fresh falling edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
    copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi};
    ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi_ncs};
    sclk_d    <= sclk_sync[SYNC_STAGES-1];
    ncs_d     <= ncs_sync[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  assign addr     = shift[8 +: ADDR_W];
  assign data     = shift[7:0];
  assign frame_ok = (bit_cnt == 5'd16) && !ovf && shift[15] && (int'(addr) < NUM_REGS);

  // Frame FSM: shift in bits, then commit or discard on chip-select release.
  // A chip-select fall seen during COMMIT is remembered so back-to-back frames
  // start from the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      ovf       <= 1'b0;
      fall_pend <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall || fall_pend) begin
            shift     <= '0;
            bit_cnt   <= '0;
            ovf       <= 1'b0;
            fall_pend <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shift <= {shift[14:0], copi_s};
            if (bit_cnt == 5'd16) ovf <= 1'b1;
            else                  bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          fall_pend <= ncs_fall;
          if (frame_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (int'(addr) == i) regs[i] <= data;
            end
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_pwm_reg_ctrl.sv
// Directed testbench for spi_pwm_reg_ctrl: drives SPI mode-0 frames from the
// pad side and compares the register outputs and pulse counts against values
// worked out by hand (plus a small register model for the ratio sweep).
module tb_spi_pwm_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       spi_sclk;
  logic       spi_copi;
  logic       spi_ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic       frame_err;

  logic [7:0] dut_regs [5];
  logic [7:0] exp_regs [5];
  int         checks;
  int         failures;
  int         strobe_cnt;
  int         err_cnt;
  logic [6:0] last_addr;

  spi_pwm_reg_ctrl #(.SYNC_STAGES(2), .NUM_REGS(5), .ADDR_W(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi_sclk        (spi_sclk),
    .spi_copi        (spi_copi),
    .spi_ncs         (spi_ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr),
    .frame_err       (frame_err)
  );

  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each pulse, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (!rst && wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_addr = wr_addr;
    end
    if (!rst && frame_err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n, input int ratio);
    int lo;
    int hi;
    lo = ratio / 2;
    hi = ratio - lo;
    for (int b = n - 1; b >= 0; b--) begin
      spi_copi = val[b];
      repeat (lo) tick();
      spi_sclk = 1'b1;
      repeat (hi) tick();
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] val, input int n, input int ratio);
    spi_ncs = 1'b0;
    repeat (2) tick();
    spi_bits(val, n, ratio);
    repeat (2) tick();
    spi_ncs = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h want=00", i, dut_regs[i]);
      end
    end
    checks++;
    if (wr_addr !== 7'd0) begin
      failures++;
      $display("FAIL reset_wr_addr got=%0d want=0", wr_addr);
    end
    repeat (20) tick();
    checks++;
    if (strobe_cnt !== 0) begin
      failures++;
      $display("FAIL reset_no_strobe got=%0d want=0", strobe_cnt);
    end
    checks++;
    if (err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_no_err got=%0d want=0", err_cnt);
    end
  endtask

  task automatic test_write();
    spi_frame(32'h80FF, 16, 4);
    exp_regs[0] = 8'hFF;
    checks++;
    if (strobe_cnt !== 1 || last_addr !== 7'd0) begin
      failures++;
      $display("FAIL write1_strobe got cnt=%0d addr=%0d want cnt=1 addr=0", strobe_cnt, last_addr);
    end
    spi_frame(32'h8455, 16, 4);
    exp_regs[4] = 8'h55;
    checks++;
    if (strobe_cnt !== 2 || last_addr !== 7'd4) begin
      failures++;
      $display("FAIL write2_strobe got cnt=%0d addr=%0d want cnt=2 addr=4", strobe_cnt, last_addr);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== exp_regs[i]) begin
        failures++;
        $display("FAIL write_reg%0d got=%h want=%h", i, dut_regs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] frames [4];
    int          lens   [4];
    frames[0] = 32'h0012;  lens[0] = 16;
    frames[1] = 32'h8512;  lens[1] = 16;
    frames[2] = 32'h4177;  lens[2] = 15;
    frames[3] = 32'h18177; lens[3] = 17;
    for (int f = 0; f < 4; f++) begin
      spi_frame(frames[f], lens[f], 4);
      checks++;
      if (err_cnt !== f + 1) begin
        failures++;
        $display("FAIL err_frame%0d got=%0d want=%0d", f, err_cnt, f + 1);
      end
    end
    checks++;
    if (strobe_cnt !== 2) begin
      failures++;
      $display("FAIL err_no_strobe got=%0d want=2", strobe_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== exp_regs[i]) begin
        failures++;
        $display("FAIL err_reg%0d got=%h want=%h", i, dut_regs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    spi_ncs = 1'b0;
    repeat (2) tick();
    spi_bits(32'h8201, 16, 4);
    repeat (2) tick();
    spi_ncs = 1'b1;
    tick();
    spi_ncs = 1'b0;
    repeat (2) tick();
    spi_bits(32'h8302, 16, 4);
    repeat (2) tick();
    spi_ncs = 1'b1;
    repeat (8) tick();
    exp_regs[2] = 8'h01;
    exp_regs[3] = 8'h02;
    checks++;
    if (strobe_cnt !== 4 || last_addr !== 7'd3) begin
      failures++;
      $display("FAIL b2b_strobe got cnt=%0d addr=%0d want cnt=4 addr=3", strobe_cnt, last_addr);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== exp_regs[i]) begin
        failures++;
        $display("FAIL b2b_reg%0d got=%h want=%h", i, dut_regs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_rst_midframe();
    spi_ncs = 1'b0;
    repeat (2) tick();
    spi_bits(32'h81, 8, 4);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    spi_bits(32'hAA, 8, 4);
    repeat (2) tick();
    spi_ncs = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    checks++;
    if (strobe_cnt !== 4 || err_cnt !== 4) begin
      failures++;
      $display("FAIL rst_drop_pulses got strobe=%0d err=%0d want strobe=4 err=4", strobe_cnt, err_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== exp_regs[i]) begin
        failures++;
        $display("FAIL rst_reg%0d got=%h want=%h", i, dut_regs[i], exp_regs[i]);
      end
    end
    spi_frame(32'h81AA, 16, 4);
    exp_regs[1] = 8'hAA;
    checks++;
    if (en_reg_out_15_8 !== 8'hAA || strobe_cnt !== 5) begin
      failures++;
      $display("FAIL rst_refill got reg=%h cnt=%0d want reg=aa cnt=5", en_reg_out_15_8, strobe_cnt);
    end
  endtask

  task automatic test_ratio_sweep();
    int          ratios [4];
    int          want_cnt;
    logic [2:0]  a;
    logic [7:0]  d;
    ratios[0] = 4; ratios[1] = 5; ratios[2] = 8; ratios[3] = 17;
    want_cnt = strobe_cnt;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        a = 3'($urandom_range(0, 4));
        d = 8'($urandom_range(0, 255));
        spi_frame({16'h0000, 1'b1, 4'b0000, a, d}, 16, ratios[r]);
        exp_regs[a] = d;
        want_cnt++;
        checks++;
        if (strobe_cnt !== want_cnt || last_addr !== {4'b0000, a}) begin
          failures++;
          $display("FAIL sweep_r%0d_strobe got cnt=%0d addr=%0d want cnt=%0d addr=%0d",
                   ratios[r], strobe_cnt, last_addr, want_cnt, a);
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dut_regs[i] !== exp_regs[i]) begin
          failures++;
          $display("FAIL sweep_r%0d_reg%0d got=%h want=%h", ratios[r], i, dut_regs[i], exp_regs[i]);
        end
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    strobe_cnt = 0;
    err_cnt    = 0;
    last_addr  = '0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    rst      = 1'b1;
    spi_sclk = 1'b0;
    spi_copi = 1'b0;
    spi_ncs  = 1'b1;
    test_reset();
    test_write();
    test_errors();
    test_back_to_back();
    test_rst_midframe();
    test_ratio_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
